lcd_hd44780_responder: RTL and testbench
========================================

Name: lcd_hd44780_responder

Overview:
- Synthesizable HD44780-compatible panel model: the responder/reader end of the 8-bit LCD bus (RS, RW, E, DATA) driven by the team's LCD initializer and writer blocks.
- Samples bus transactions on E falling edge and decodes instructions and data into internal state and a DDRAM array.
- Enforces the power-on init sequence and busy timing, and drives the busy flag, address counter and DDRAM data back on reads.
- Used as the loopback/bench target for all LCD host-side logic; 50 MHz clk.

Parameters:
- POR_CYCLES, 750_000: minimum clk cycles from reset release to first function set (15 ms).
- FS2_GAP_CYCLES, 205_000: minimum gap FS1->FS2 (4.1 ms).
- FS3_GAP_CYCLES, 5_000: minimum gap FS2->FS3 (100 us).
- BUSY_CMD_CYCLES, 2_000: BF high time after a normal write (40 us).
- BUSY_LONG_CYCLES, 76_500: BF high time after clear/home (1.53 ms).
- SYNC_STAGES, 2: synchronizer depth on RS/RW/E.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- RS  in  1  register select (0 instr, 1 data)
- RW  in  1  1 read, 0 write
- E  in  1  enable strobe
- DATA  inout  8  bus; driven only during read windows, else Z
- ready  out  1  init sequence complete
- busy  out  1  internal BF
- protocol_error  out  1  sticky violation flag
- display_on  out  1  D bit of display control
- ac  out  7  address counter
- peek_addr  in  7  bench DDRAM read address
- peek_data  out  8  DDRAM[peek_addr], combinational

Behaviour:
- Reset (async, reset_n=0): state POR_BUSY, counter 0, busy=1, ready=0, protocol_error=0, display_on=0, ac=0, I/D=1, S=0, DATA=Z. DDRAM contents undefined until first clear.
- RS/RW/E pass through SYNC_STAGES flops; the E falling edge (sync'd E 1->0) is the commit strobe. DATA is captured from the last sync stage aligned with E. Commit occurs SYNC_STAGES+1 cycles after the pin edge.
- Read window: DATA driven while RW_sync=1 and E_sync=1.
  - RS=0: drives {busy, ac}.
  - RS=1: drives DDRAM[ac]; ac advances at that read's E fall.
- Init FSM:
  - POR_BUSY: counts to POR_CYCLES, then WAIT_FS1. A write here sets protocol_error and restarts the count.
  - WAIT_FS1 -> WAIT_FS2 -> WAIT_FS3 -> READY: each transition on a write with DATA[7:4]=4'h3. The gap since the previous FS must be >= FS2_GAP_CYCLES (FS1->FS2) or FS3_GAP_CYCLES (FS2->FS3).
  - Short gap or non-0x3X write: protocol_error=1, return to WAIT_FS1.
  - Reads before READY return BF=1 and do not advance ac.
  - Entering READY: ready=1, busy=1 for BUSY_CMD_CYCLES.
- READY instruction decode (RS=0, RW=0) by highest set bit:
  - 0x01 clear: fill DDRAM with 0x20, one entry/cycle over 80 cycles; ac=0, I/D=1; long busy.
  - 0x02/03 home: ac=0; long busy.
  - 0x04-07 entry mode: I/D=DATA[1], S=DATA[0].
  - 0x08-0F display control: display_on=DATA[2]; C and B are stored.
  - 0x10-1F cursor/shift: S/C=0 moves ac by R/L; display shift is stored, not rendered.
  - 0x20-3F function set: DL/N/F stored. DL=0 sets protocol_error (4-bit mode unsupported).
  - 0x40-7F CGRAM address: accepted, stored, no effect on DDRAM.
  - 0x80-FF: ac=DATA[6:0].
  - All non-long commands give normal busy.
- Data write (RS=1, RW=0): DDRAM[ac]=DATA; ac steps by I/D; normal busy.
- ac map (2-line): 0x00-0x27 and 0x40-0x67.
  - Increment: 0x27->0x40, 0x67->0x00.
  - Decrement: 0x00->0x67, 0x40->0x27.
  - Set to an unmapped address: store as given; next step wraps per the above.
- Any write while busy=1 in READY: ignored, protocol_error=1. Reads while busy are legal.
- busy counter: reload on accept, decrement each clk, busy clears the cycle the counter hits 0.
- Reset asserted mid-clear or mid-busy: everything returns to reset values immediately.

Decomposition:
- lcd_pkg holds:
  - instruction opcode masks
  - default timing constants
  - init state enum (POR_BUSY, WAIT_FS1, WAIT_FS2, WAIT_FS3, READY)
  - ac wrap function
- Sub-module lcd_ddram: 80x8 array, one write port with the clear sequencer muxed in, two async read ports (bus, peek). Linear index mapping: line 2 uses offset 40.

Test Plan:
- Run the team initializer against the responder -> ready=1 after FS3; DDRAM all 0x20 after 0x01; display_on=1; protocol_error=0; ac=0.
- FS2 issued 100_000 cycles after FS1 -> protocol_error=1, state WAIT_FS1, ready=0.
- After init, write 0x80|0x27, then data 0x41, 0x42 -> DDRAM[0x27]=0x41, DDRAM[0x40]=0x42 via peek; ac=0x41.
- Entry mode 0x04, set ac 0x00, write 0x55 -> ac=0x67, DDRAM[0x00]=0x55.
- Instruction read immediately after data write -> DATA=8'h80|ac with BF=1; read after 2_000 cycles -> BF=0.
- Write during busy after 0x01 -> write ignored, protocol_error=1. Pulse reset_n low mid-clear -> busy=1, ready=0, ac=0, DATA=Z.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared constants, opcode masks, init states and AC stepping for
//            the HD44780 responder.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int unsigned c_por_cycles       = 750_000;
    localparam int unsigned c_fs2_gap_cycles   = 205_000;
    localparam int unsigned c_fs3_gap_cycles   = 5_000;
    localparam int unsigned c_busy_cmd_cycles  = 2_000;
    localparam int unsigned c_busy_long_cycles = 76_500;

    localparam logic [2:0] c_st_por_busy = 3'd0;
    localparam logic [2:0] c_st_wait_fs1 = 3'd1;
    localparam logic [2:0] c_st_wait_fs2 = 3'd2;
    localparam logic [2:0] c_st_wait_fs3 = 3'd3;
    localparam logic [2:0] c_st_ready    = 3'd4;

    // Instruction classes, decoded by highest set bit
    localparam logic [7:0] c_op_clear    = 8'b0000_0001;
    localparam logic [7:0] c_op_home     = 8'b0000_001?;
    localparam logic [7:0] c_op_entry    = 8'b0000_01??;
    localparam logic [7:0] c_op_display  = 8'b0000_1???;
    localparam logic [7:0] c_op_shift    = 8'b0001_????;
    localparam logic [7:0] c_op_function = 8'b001?_????;
    localparam logic [7:0] c_op_cgram    = 8'b01??_????;
    localparam logic [7:0] c_op_ddram    = 8'b1???_????;

    localparam logic [3:0] c_fs_nibble   = 4'h3;
    localparam logic [7:0] c_space       = 8'h20;
    localparam int         c_ddram_depth = 80;
    localparam logic [6:0] c_clr_last    = 7'd79;

    typedef struct packed {
        logic       id;
        logic       s;
        logic       d;
        logic       c;
        logic       b;
        logic       dl;
        logic       n;
        logic       f;
        logic       sc;
        logic       rl;
        logic [5:0] cgram;
    } lcd_cfg_t;

    // Two-line AC walk; unmapped addresses fall onto the nearest line boundary
    function automatic logic [6:0] lcd_ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (!ac[6]) nxt = (ac >= 7'h27) ? 7'h40 : ac + 7'd1;
            else        nxt = (ac >= 7'h67) ? 7'h00 : ac + 7'd1;
        end else begin
            if (!ac[6]) nxt = (ac == 7'h00) ? 7'h67 : ((ac > 7'h27) ? 7'h27 : ac - 7'd1);
            else        nxt = (ac == 7'h40) ? 7'h27 : ((ac > 7'h67) ? 7'h67 : ac - 7'd1);
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ddram.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ddram
// Brief    : 80x8 display RAM, one write port shared with the clear sequencer,
//            two asynchronous read ports addressed in AC space.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       i_we,
    input  logic [6:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic       i_clr_we,
    input  logic [6:0] i_clr_idx,
    input  logic [6:0] i_raddr_a,
    output logic [7:0] o_rdata_a,
    input  logic [6:0] i_raddr_b,
    output logic [7:0] o_rdata_b
);

    logic [7:0] r_mem [c_ddram_depth];

    function automatic logic [6:0] f_index(input logic [6:0] a);
        return a[6] ? ({1'b0, a[5:0]} + 7'd40) : {1'b0, a[5:0]};
    endfunction

    function automatic logic f_valid(input logic [6:0] a);
        return (a[5:0] < 6'd40);
    endfunction

    logic w_wvalid;
    assign w_wvalid = f_valid(i_waddr);

    always_ff @(posedge clk) begin
        if (i_clr_we) begin
            r_mem[i_clr_idx] <= c_space;
        end else if (i_we && w_wvalid) begin
            r_mem[f_index(i_waddr)] <= i_wdata;
        end
    end

    // Unmapped addresses have no cell behind them and read back as blank
    assign o_rdata_a = f_valid(i_raddr_a) ? r_mem[f_index(i_raddr_a)] : c_space;
    assign o_rdata_b = f_valid(i_raddr_b) ? r_mem[f_index(i_raddr_b)] : c_space;

endmodule
`default_nettype wire

// File: rtl/lcd_hd44780_responder.sv
`default_nettype none
// ============================================================================
// Module   : lcd_hd44780_responder
// Brief    : HD44780-compatible panel model on the 8-bit bus: init sequence
//            checking, busy timing, instruction/data decode and read-back.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int unsigned POR_CYCLES       = c_por_cycles,
    parameter int unsigned FS2_GAP_CYCLES   = c_fs2_gap_cycles,
    parameter int unsigned FS3_GAP_CYCLES   = c_fs3_gap_cycles,
    parameter int unsigned BUSY_CMD_CYCLES  = c_busy_cmd_cycles,
    parameter int unsigned BUSY_LONG_CYCLES = c_busy_long_cycles,
    parameter int          SYNC_STAGES      = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       RS,
    input  logic       RW,
    input  logic       E,
    inout  wire  [7:0] DATA,
    output logic       ready,
    output logic       busy,
    output logic       protocol_error,
    output logic       display_on,
    output logic [6:0] ac,
    input  logic [6:0] peek_addr,
    output logic [7:0] peek_data
);

    logic [10:0] r_sync [SYNC_STAGES];
    logic        r_e_q;
    logic        r_lat_rs;
    logic        r_lat_rw;
    logic [7:0]  r_lat_data;

    logic [2:0]  r_state;
    logic [31:0] r_tmr;
    logic [31:0] r_bcnt;
    logic        r_busy;
    logic        r_ready;
    logic        r_err;
    logic [6:0]  r_ac;
    lcd_cfg_t    r_cfg;
    logic        r_clr_active;
    logic [6:0]  r_clr_idx;

    logic        w_rs_s;
    logic        w_rw_s;
    logic        w_e_s;
    logic        w_commit;
    logic        w_wr;
    logic        w_rd;
    logic        w_fs;
    logic        w_long;
    logic        w_dwe;
    logic        w_drive;
    logic [7:0]  w_bus_ddram;
    logic [7:0]  w_rd_data;

    assign w_rs_s = r_sync[SYNC_STAGES-1][10];
    assign w_rw_s = r_sync[SYNC_STAGES-1][9];
    assign w_e_s  = r_sync[SYNC_STAGES-1][8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_e_q      <= 1'b0;
            r_lat_rs   <= 1'b0;
            r_lat_rw   <= 1'b0;
            r_lat_data <= '0;
        end else begin
            r_sync[0] <= {RS, RW, E, DATA};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_e_q <= w_e_s;
            // Hold the bus fields seen while E was high so the fall commits them
            if (w_e_s) begin
                r_lat_rs   <= w_rs_s;
                r_lat_rw   <= w_rw_s;
                r_lat_data <= r_sync[SYNC_STAGES-1][7:0];
            end
        end
    end

    assign w_commit = r_e_q & ~w_e_s;
    assign w_wr     = w_commit & ~r_lat_rw;
    assign w_rd     = w_commit &  r_lat_rw;
    assign w_fs     = ~r_lat_rs && (r_lat_data[7:4] == c_fs_nibble);
    assign w_long   = (r_lat_data[7:2] == 6'd0) && (r_lat_data[1:0] != 2'd0);
    assign w_dwe    = w_wr && r_lat_rs && (r_state == c_st_ready) && !r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_st_por_busy;
            r_tmr        <= '0;
            r_bcnt       <= '0;
            r_busy       <= 1'b1;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
            r_ac         <= '0;
            r_cfg        <= '0;
            r_cfg.id     <= 1'b1;
            r_clr_active <= 1'b0;
            r_clr_idx    <= '0;
        end else begin
            if (r_tmr != '1) r_tmr <= r_tmr + 32'd1;
            if (r_bcnt != '0) begin
                r_bcnt <= r_bcnt - 32'd1;
                if (r_bcnt == 32'd1) r_busy <= 1'b0;
            end
            if (r_clr_active) begin
                if (r_clr_idx == c_clr_last) r_clr_active <= 1'b0;
                r_clr_idx <= r_clr_idx + 7'd1;
            end

            case (r_state)
                c_st_por_busy: begin
                    if (w_wr) begin
                        r_err <= 1'b1;
                        r_tmr <= '0;
                    end else if (r_tmr >= POR_CYCLES - 32'd1) begin
                        r_state <= c_st_wait_fs1;
                    end
                end
                c_st_wait_fs1: begin
                    if (w_wr) begin
                        if (w_fs) begin
                            r_state <= c_st_wait_fs2;
                            r_tmr   <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_st_wait_fs2: begin
                    if (w_wr) begin
                        if (w_fs && (r_tmr >= FS2_GAP_CYCLES - 32'd1)) begin
                            r_state <= c_st_wait_fs3;
                            r_tmr   <= '0;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= c_st_wait_fs1;
                        end
                    end
                end
                c_st_wait_fs3: begin
                    if (w_wr) begin
                        if (w_fs && (r_tmr >= FS3_GAP_CYCLES - 32'd1)) begin
                            r_state  <= c_st_ready;
                            r_ready  <= 1'b1;
                            r_busy   <= 1'b1;
                            r_bcnt   <= BUSY_CMD_CYCLES;
                            r_cfg.dl <= r_lat_data[4];
                            r_cfg.n  <= r_lat_data[3];
                            r_cfg.f  <= r_lat_data[2];
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= c_st_wait_fs1;
                        end
                    end
                end
                c_st_ready: begin
                    if (w_wr && r_busy) begin
                        r_err <= 1'b1;
                    end else if (w_wr) begin
                        r_busy <= 1'b1;
                        r_bcnt <= (!r_lat_rs && w_long) ? BUSY_LONG_CYCLES : BUSY_CMD_CYCLES;
                        if (r_lat_rs) begin
                            r_ac <= lcd_ac_step(r_ac, r_cfg.id);
                        end else begin
                            casez (r_lat_data)
                                c_op_ddram: r_ac <= r_lat_data[6:0];
                                c_op_cgram: r_cfg.cgram <= r_lat_data[5:0];
                                c_op_function: begin
                                    r_cfg.dl <= r_lat_data[4];
                                    r_cfg.n  <= r_lat_data[3];
                                    r_cfg.f  <= r_lat_data[2];
                                    if (!r_lat_data[4]) r_err <= 1'b1;
                                end
                                c_op_shift: begin
                                    r_cfg.sc <= r_lat_data[3];
                                    r_cfg.rl <= r_lat_data[2];
                                    if (!r_lat_data[3]) r_ac <= lcd_ac_step(r_ac, r_lat_data[2]);
                                end
                                c_op_display: begin
                                    r_cfg.d <= r_lat_data[2];
                                    r_cfg.c <= r_lat_data[1];
                                    r_cfg.b <= r_lat_data[0];
                                end
                                c_op_entry: begin
                                    r_cfg.id <= r_lat_data[1];
                                    r_cfg.s  <= r_lat_data[0];
                                end
                                c_op_home: r_ac <= '0;
                                c_op_clear: begin
                                    r_ac         <= '0;
                                    r_cfg.id     <= 1'b1;
                                    r_clr_active <= 1'b1;
                                    r_clr_idx    <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end else if (w_rd && r_lat_rs) begin
                        r_ac <= lcd_ac_step(r_ac, r_cfg.id);
                    end
                end
                default: r_state <= c_st_por_busy;
            endcase
        end
    end

    lcd_ddram u_ddram (
        .clk       (clk),
        .i_we      (w_dwe),
        .i_waddr   (r_ac),
        .i_wdata   (r_lat_data),
        .i_clr_we  (r_clr_active),
        .i_clr_idx (r_clr_idx),
        .i_raddr_a (r_ac),
        .o_rdata_a (w_bus_ddram),
        .i_raddr_b (peek_addr),
        .o_rdata_b (peek_data)
    );

    // BF reads high throughout init regardless of the busy timer
    assign w_drive   = w_rw_s & w_e_s;
    assign w_rd_data = w_rs_s ? w_bus_ddram : {(r_busy | ~r_ready), r_ac};
    assign DATA      = w_drive ? w_rd_data : 8'bz;

    assign ready          = r_ready;
    assign busy           = r_busy;
    assign protocol_error = r_err;
    assign display_on     = r_cfg.d;
    assign ac             = r_ac;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_hd44780_responder
// Brief    : Directed self-checking bench for the HD44780 responder with
//            shortened timing parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_hd44780_responder;

    localparam int unsigned c_por  = 200;
    localparam int unsigned c_fs2  = 100;
    localparam int unsigned c_fs3  = 20;
    localparam int unsigned c_cmd  = 30;
    localparam int unsigned c_long = 150;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       RS, RW, E;
    wire  [7:0] DATA;
    logic [7:0] r_drv;
    logic       r_drv_en;
    logic       ready, busy, protocol_error, display_on;
    logic [6:0] ac;
    logic [6:0] peek_addr;
    logic [7:0] peek_data;
    logic [7:0] r_rd;
    logic [7:0] r_pk;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_bad;

    assign DATA = r_drv_en ? r_drv : 8'bz;

    always #10 clk = ~clk;

    lcd_hd44780_responder #(
        .POR_CYCLES       (c_por),
        .FS2_GAP_CYCLES   (c_fs2),
        .FS3_GAP_CYCLES   (c_fs3),
        .BUSY_CMD_CYCLES  (c_cmd),
        .BUSY_LONG_CYCLES (c_long),
        .SYNC_STAGES      (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .RS             (RS),
        .RW             (RW),
        .E              (E),
        .DATA           (DATA),
        .ready          (ready),
        .busy           (busy),
        .protocol_error (protocol_error),
        .display_on     (display_on),
        .ac             (ac),
        .peek_addr      (peek_addr),
        .peek_data      (peek_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        RS = rs; RW = 1'b0; r_drv = d; r_drv_en = 1'b1;
        repeat (2) @(negedge clk);
        E = 1'b1;
        repeat (4) @(negedge clk);
        E = 1'b0;
        repeat (4) @(negedge clk);
        r_drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] d);
        @(negedge clk);
        RS = rs; RW = 1'b1; r_drv_en = 1'b0; E = 1'b1;
        repeat (4) @(negedge clk);
        d = DATA;
        E = 1'b0;
        repeat (4) @(negedge clk);
        RW = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while (busy && k < max) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic peek(input logic [6:0] a, output logic [7:0] d);
        peek_addr = a;
        #1 d = peek_data;
    endtask

    initial begin
        reset_n = 1'b0; RS = 1'b0; RW = 1'b0; E = 1'b0;
        r_drv = 8'h00; r_drv_en = 1'b0; peek_addr = 7'h00;
        repeat (5) @(negedge clk);
        check("rst_busy",  {31'd0, busy}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_err",   {31'd0, protocol_error}, 32'd0);
        check("rst_disp",  {31'd0, display_on}, 32'd0);
        check("rst_ac",    {25'd0, ac}, 32'd0);
        reset_n = 1'b1;

        // FS2 arriving well inside the FS1->FS2 gap
        repeat (c_por + 10) @(negedge clk);
        bus_write(1'b0, 8'h38);
        repeat (40) @(negedge clk);
        bus_write(1'b0, 8'h38);
        check("short_gap_err",   {31'd0, protocol_error}, 32'd1);
        check("short_gap_ready", {31'd0, ready}, 32'd0);
        check("short_gap_state", {29'd0, dut.r_state}, 32'd1);

        @(negedge clk) reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Host initializer sequence
        repeat (c_por + 10) @(negedge clk);
        bus_write(1'b0, 8'h38);
        repeat (c_fs2 + 5) @(negedge clk);
        bus_write(1'b0, 8'h38);
        repeat (c_fs3 + 5) @(negedge clk);
        bus_write(1'b0, 8'h38);
        check("ready_after_fs3", {31'd0, ready}, 32'd1);
        wait_idle(200);
        bus_write(1'b0, 8'h38); wait_idle(200);
        bus_write(1'b0, 8'h0C); wait_idle(200);
        bus_write(1'b0, 8'h01); wait_idle(400);
        bus_write(1'b0, 8'h06); wait_idle(200);
        check("init_disp", {31'd0, display_on}, 32'd1);
        check("init_err",  {31'd0, protocol_error}, 32'd0);
        check("init_ac",   {25'd0, ac}, 32'd0);
        n_bad = 0;
        for (int i = 0; i < 40; i++) begin
            peek(7'(i), r_pk);
            if (r_pk != 8'h20) n_bad++;
            peek(7'(i + 64), r_pk);
            if (r_pk != 8'h20) n_bad++;
        end
        check("clear_fill", n_bad, 32'd0);

        // Line-1 end wraps to line-2 start
        bus_write(1'b0, 8'hA7); wait_idle(200);
        bus_write(1'b1, 8'h41); wait_idle(200);
        bus_write(1'b1, 8'h42); wait_idle(200);
        peek(7'h27, r_pk); check("wrap_d27", {24'd0, r_pk}, 32'h41);
        peek(7'h40, r_pk); check("wrap_d40", {24'd0, r_pk}, 32'h42);
        check("wrap_ac", {25'd0, ac}, 32'h41);

        // Decrement from 0x00 wraps to 0x67
        bus_write(1'b0, 8'h04); wait_idle(200);
        bus_write(1'b0, 8'h80); wait_idle(200);
        bus_write(1'b1, 8'h55); wait_idle(200);
        check("dec_ac", {25'd0, ac}, 32'h67);
        peek(7'h00, r_pk); check("dec_d00", {24'd0, r_pk}, 32'h55);

        // Busy flag read-back right after a data write and after timeout
        bus_write(1'b0, 8'h06); wait_idle(200);
        bus_write(1'b0, 8'h85); wait_idle(200);
        bus_write(1'b1, 8'h33);
        bus_read(1'b0, r_rd);
        check("bf_busy_read", {24'd0, r_rd}, 32'h86);
        repeat (c_cmd + 10) @(negedge clk);
        bus_read(1'b0, r_rd);
        check("bf_idle_read", {24'd0, r_rd}, 32'h06);
        peek(7'h05, r_pk); check("data_d05", {24'd0, r_pk}, 32'h33);

        // Data read returns DDRAM[ac] and advances ac across the wrap
        bus_write(1'b0, 8'hA7); wait_idle(200);
        bus_read(1'b1, r_rd);
        check("data_read", {24'd0, r_rd}, 32'h41);
        check("data_read_ac", {25'd0, ac}, 32'h40);
        bus_write(1'b0, 8'h10); wait_idle(200);
        check("cursor_left_ac", {25'd0, ac}, 32'h27);

        // Write during clear busy is rejected
        check("err_before_busy_write", {31'd0, protocol_error}, 32'd0);
        bus_write(1'b0, 8'h01);
        bus_write(1'b1, 8'h99);
        check("busy_write_err", {31'd0, protocol_error}, 32'd1);
        check("busy_write_ac",  {25'd0, ac}, 32'd0);
        wait_idle(400);
        peek(7'h00, r_pk); check("busy_write_d00", {24'd0, r_pk}, 32'h20);

        // Reset mid-clear
        bus_write(1'b0, 8'h01);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midclr_busy",  {31'd0, busy}, 32'd1);
        check("midclr_ready", {31'd0, ready}, 32'd0);
        check("midclr_ac",    {25'd0, ac}, 32'd0);
        check("midclr_err",   {31'd0, protocol_error}, 32'd0);
        check("midclr_disp",  {31'd0, display_on}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
